// File: rtl/freq_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : freq_disp_pkg
// Purpose  : Shared definitions for the frequency display path: default
//            widths, the binary-to-BCD converter state encoding and a helper
//            that sizes the iteration counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package freq_disp_pkg;

  localparam int c_BIN_W_DEF  = 32;
  localparam int c_DIGITS_DEF = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // The counter must be able to hold the value bin_w itself.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module   : bcd_add3
// Purpose  : Double-dabble correction cell for one BCD digit.
//            A digit of 5 or more gets +3 so that the following left shift
//            carries correctly into the next decimal digit.
// Ports    : i_digit [3:0] - BCD digit before correction
//            o_digit [3:0] - corrected digit
// Revision : 1.0 - initial release
// ============================================================================
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Inputs are at most 9, so the result never exceeds 12 and fits in 4 bits.
  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/freq_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module   : freq_bcd_conv
// Purpose  : Sequential binary-to-BCD converter (double-dabble, one bit per
//            clock) for the frequency readout. A conversion starts only when
//            freq_in differs from the last converted value. Each result is
//            announced with a one-cycle bcd_valid pulse plus a count of
//            significant digits for leading-zero blanking.
// Ports    : clk            - system clock
//            rst            - synchronous active-high reset
//            freq_in   [BIN_W-1:0]    - binary frequency (Hz)
//            bcd_out   [4*DIGITS-1:0] - packed BCD, digit 0 in [3:0]
//            digit_cnt [3:0]          - significant digits, 1..DIGITS
//            bcd_valid      - one-cycle pulse on output update
//            busy           - conversion in flight
// Revision : 1.0 - initial release
// ============================================================================
module freq_bcd_conv
  import freq_disp_pkg::*;
#(
  parameter int BIN_W  = c_BIN_W_DEF,
  parameter int DIGITS = c_DIGITS_DEF   // 10^DIGITS > 2^BIN_W-1, DIGITS <= 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      freq_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [3:0]            digit_cnt,
  output logic                  bcd_valid,
  output logic                  busy
);

  localparam int c_BCD_W  = 4 * DIGITS;
  localparam int c_WORK_W = BIN_W + c_BCD_W;
  localparam int c_CNT_W  = cnt_width(BIN_W);

  // Work register: BCD field in the upper bits, binary field below it.
  logic [c_WORK_W-1:0] r_work;
  logic [BIN_W-1:0]    r_freq_last;
  logic [c_CNT_W-1:0]  r_cnt;
  state_t              r_state;

  logic [c_BCD_W-1:0]  w_bcd_adj;
  logic [3:0]          w_digit_cnt;

  // Per-digit add-3 correction, all digits in parallel.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .i_digit (r_work[BIN_W + 4*gi +: 4]),
        .o_digit (w_bcd_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Priority encoder: highest nonzero digit index + 1, floor of 1 for zero.
  always_comb begin
    w_digit_cnt = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_work[BIN_W + 4*i +: 4] != 4'd0) begin
        w_digit_cnt = 4'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_freq_last <= '0;
      r_cnt       <= '0;
      bcd_out     <= '0;
      digit_cnt   <= 4'd1;
      bcd_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (freq_in != r_freq_last) begin
            r_work      <= {{c_BCD_W{1'b0}}, freq_in};
            r_freq_last <= freq_in;
            r_cnt       <= '0;
            busy        <= 1'b1;
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Correct first, then shift the whole register; the MSB of the
          // corrected BCD field is always 0 for legal parameters.
          r_work <= {w_bcd_adj, r_work[BIN_W-1:0]} << 1;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == c_CNT_W'(BIN_W - 1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          bcd_out   <= r_work[c_WORK_W-1 -: c_BCD_W];
          digit_cnt <= w_digit_cnt;
          bcd_valid <= 1'b1;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_bcd_conv
// Purpose  : Scoreboard bench for freq_bcd_conv. Stimulus pushes expected
//            results (value, digit count, cycle of the valid pulse); a
//            monitor pops and compares on every bcd_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_bcd_conv;

  typedef struct {
    logic [39:0] bcd;
    logic [3:0]  cnt;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] freq_in = '0;
  logic [39:0] bcd_out;
  logic [3:0]  digit_cnt;
  logic        bcd_valid;
  logic        busy;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   valid_count = 0;

  freq_bcd_conv #(.BIN_W(32), .DIGITS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .freq_in   (freq_in),
    .bcd_out   (bcd_out),
    .digit_cnt (digit_cnt),
    .bcd_valid (bcd_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  // Monitor: every valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bcd_valid === 1'b1) begin
      exp_t e;
      valid_count++;
      if (q.size() == 0) begin
        chk("unexpected_valid", {24'd0, bcd_out}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("bcd_out", {24'd0, bcd_out}, {24'd0, e.bcd});
        chk("digit_cnt", {60'd0, digit_cnt}, {60'd0, e.cnt});
        chk("valid_cycle", 64'(cyc), 64'(e.cyc));
        chk("busy_in_valid", {63'd0, busy}, 64'd0);
      end
    end
  end

  // Set freq_in on a negedge; if idle, the next posedge is the capture edge.
  task automatic drive(input logic [31:0] v, output int c);
    @(negedge clk);
    c = cyc;
    freq_in = v;
  endtask

  task automatic push(input logic [39:0] b, input logic [3:0] n, input int at);
    exp_t e;
    e.bcd = b; e.cnt = n; e.cyc = at;
    q.push_back(e);
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while (q.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int c;
    int vc;
    int nbusy;

    // Reset / zero input
    freq_in = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bcd", {24'd0, bcd_out}, 64'd0);
    chk("rst_cnt", {60'd0, digit_cnt}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    vc = valid_count;
    repeat (100) @(negedge clk);
    chk("zero_no_valid", 64'(valid_count - vc), 64'd0);

    // Normal value, with busy window check
    drive(32'd1_234_567, c);
    push(40'h00_0123_4567, 4'd7, c + 34);
    nbusy = 0;
    repeat (33) begin
      @(negedge clk);
      if (busy === 1'b1) nbusy++;
    end
    chk("busy_cycles", 64'(nbusy), 64'd33);
    drain(80);

    // Full scale then a single digit
    drive(32'hFFFF_FFFF, c);
    push(40'h42_9496_7295, 4'd10, c + 34);
    drain(80);
    drive(32'd9, c);
    push(40'h00_0000_0009, 4'd1, c + 34);
    drain(80);

    // Change while busy: 2000 dropped, 3000 captured at first IDLE edge
    drive(32'd1000, c);
    push(40'h00_0000_1000, 4'd4, c + 34);
    push(40'h00_0000_3000, 4'd4, c + 68);
    repeat (5) @(negedge clk);
    freq_in = 32'd2000;
    repeat (5) @(negedge clk);
    freq_in = 32'd3000;
    drain(120);

    // Reset during SHIFT iteration 15
    drive(32'd50_000, c);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_bcd", {24'd0, bcd_out}, 64'd0);
    chk("midrst_cnt", {60'd0, digit_cnt}, 64'd1);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_valid", {63'd0, bcd_valid}, 64'd0);
    push(40'h00_0005_0000, 4'd5, c + 50);
    drain(80);

    // Repeat value across two upstream updates
    vc = valid_count;
    drive(32'd777, c);
    push(40'h00_0000_0777, 4'd3, c + 34);
    drain(80);
    drive(32'd777, c);
    repeat (100) @(negedge clk);
    chk("repeat_one_pulse", 64'(valid_count - vc), 64'd1);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected finish", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
